// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boot_pkg
//  Description : Shared types and constants for the boot loader: frame-parser
//                state encoding, error codes reported on err_o and the
//                default instruction-cache depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package boot_pkg;

    // Frame-parser states
    typedef enum logic [2:0] {
        LEN   = 3'd0,
        DATA  = 3'd1,
        CSUM  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } state_t;

    // Error codes driven on err_o
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_LEN     = 2'b11;

    // Word capacity of the default 6-bit-addressed instruction cache
    localparam int MAX_WORDS = 64;

    // Word capacity for an arbitrary cache address width
    function automatic int max_words(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/boot_timer.sv
`default_nettype none
// ============================================================================
//  Module      : boot_timer
//  Description : Idle counter for the boot loader. Counts enabled cycles since
//                the last clear and flags expiry once TIMEOUT cycles have
//                elapsed; the count saturates at TIMEOUT.
//  Ports       : clk_i     - clock
//                rst_i     - synchronous active-high reset
//                clear_i   - restart the count at zero (wins over enable_i)
//                enable_i  - count this cycle
//                expired_o - TIMEOUT idle cycles have elapsed
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

    logic [c_cnt_w-1:0] r_count;
    logic               w_expired;

    assign w_expired = (r_count == c_limit);
    assign expired_o = w_expired;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= '0;
        end else if (enable_i && !w_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : boot_loader
//  Description : Receives a program image as a byte stream (length byte L,
//                4*L little-endian data bytes, one checksum byte), writes the
//                words into the instruction cache and releases the core from
//                reset once the 8-bit additive checksum verifies.
//  Ports       : clk_i, rst_i      - clock, synchronous active-high reset
//                byte_valid_i/_data_i, byte_ready_o - byte stream handshake
//                imem_we_o/_addr_o/_data_o          - cache write port
//                core_rst_o        - core held in reset while 1
//                done_o            - image loaded and verified
//                err_o             - 00 none, 01 csum, 10 timeout, 11 length
//                words_o           - words written so far
//  Revision    : 1.0 - initial release
// ============================================================================
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              core_rst_o,
    output logic              done_o,
    output logic [1:0]        err_o,
    output logic [ADDR_W:0]   words_o
);

    localparam int c_max_words = max_words(ADDR_W);

    state_t              r_state;
    logic                r_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data;
    logic                r_core_rst;
    logic                r_done;
    logic [1:0]          r_err;
    logic [ADDR_W:0]     r_words;
    logic [ADDR_W:0]     r_len;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_buf;      // first three bytes of the current word
    logic [7:0]          r_csum;

    logic                w_hs;
    logic                w_expired;
    logic                w_in_frame;
    logic [ADDR_W:0]     w_words_next;
    logic                w_len_bad;

    assign w_hs         = byte_valid_i & r_ready;
    assign w_in_frame   = (r_state == DATA) || (r_state == CSUM);
    assign w_words_next = r_words + 1'b1;
    assign w_len_bad    = (byte_data_i == 8'd0) || (int'(byte_data_i) > c_max_words);

    // Idle time only matters inside a frame; outside it the counter is held clear.
    boot_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_hs || !w_in_frame),
        .enable_i  (w_in_frame),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= LEN;
            r_ready    <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= ERR_NONE;
            r_words    <= '0;
            r_len      <= '0;
            r_byte_idx <= '0;
            r_buf      <= '0;
            r_csum     <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                LEN: begin
                    if (w_hs) begin
                        if (w_len_bad) begin
                            r_state <= ERROR;
                            r_err   <= ERR_LEN;
                            r_ready <= 1'b0;
                        end else begin
                            r_len      <= (ADDR_W+1)'(byte_data_i);
                            r_byte_idx <= '0;
                            r_words    <= '0;
                            r_csum     <= byte_data_i;
                            r_state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        r_csum     <= r_csum + byte_data_i;
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 2'd3) begin
                            // words_o doubles as the word index of the word being completed
                            r_we    <= 1'b1;
                            r_addr  <= r_words[ADDR_W-1:0];
                            r_data  <= {byte_data_i, r_buf};
                            r_words <= w_words_next;
                            if (w_words_next == r_len) begin
                                r_state <= CSUM;
                            end
                        end else begin
                            // Shift in from the top so byte 0 ends up in the low lane
                            r_buf <= {byte_data_i, r_buf[23:8]};
                        end
                    end else if (w_expired) begin
                        r_state <= ERROR;
                        r_err   <= ERR_TIMEOUT;
                        r_ready <= 1'b0;
                    end
                end
                CSUM: begin
                    if (w_hs) begin
                        r_ready <= 1'b0;
                        if (byte_data_i == r_csum) begin
                            r_state    <= RUN;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= ERROR;
                            r_err   <= ERR_CSUM;
                        end
                    end else if (w_expired) begin
                        r_state <= ERROR;
                        r_err   <= ERR_TIMEOUT;
                        r_ready <= 1'b0;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                ERROR: begin
                    r_state <= ERROR;
                end
                default: begin
                    r_state <= ERROR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o = r_ready;
    assign imem_we_o    = r_we;
    assign imem_addr_o  = r_addr;
    assign imem_data_o  = r_data;
    assign core_rst_o   = r_core_rst;
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign words_o      = r_words;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boot_loader
//  Description : Self-checking bench for boot_loader. Frames are built in a
//                queue; expected writes, error code and status come from a
//                frame-level reference model computed from the frame bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boot_loader;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;
    localparam int MAXW    = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              byte_valid_i = 1'b0;
    logic [7:0]        byte_data_i = 8'h00;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_data_o;
    logic              core_rst_o;
    logic              done_o;
    logic [1:0]        err_o;
    logic [ADDR_W:0]   words_o;

    boot_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .core_rst_o   (core_rst_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_o      (words_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;
    int last_hs = 0;

    logic [7:0]  frame[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    // Every cycle with the strobe high is one recorded write
    always @(negedge clk) begin
        if (imem_we_o === 1'b1) begin
            got_addr.push_back(32'(imem_addr_o));
            got_data.push_back(imem_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ready"},    32'(byte_ready_o), 32'd1);
        check({tag, ".we"},       32'(imem_we_o),    32'd0);
        check({tag, ".addr"},     32'(imem_addr_o),  32'd0);
        check({tag, ".data"},     imem_data_o,       32'd0);
        check({tag, ".core_rst"}, 32'(core_rst_o),   32'd1);
        check({tag, ".done"},     32'(done_o),       32'd0);
        check({tag, ".err"},      32'(err_o),        32'd0);
        check({tag, ".words"},    32'(words_o),      32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit rnd, output bit ok);
        logic hs;
        ok = 1'b0;
        if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        for (int n = 0; n < 20 && !ok; n++) begin
            hs = byte_ready_o;
            @(negedge clk);
            if (hs) ok = 1'b1;
        end
        byte_valid_i = 1'b0;
        if (ok) last_hs = cyc;
    endtask

    task automatic send_frame(input bit rnd);
        bit ok;
        foreach (frame[i]) begin
            send_byte(frame[i], rnd, ok);
            if (!ok) begin
                check("send_frame.accept", 32'(i), 32'hFFFF_FFFF);
                return;
            end
        end
    endtask

    task automatic make_frame(input int len, input bit good);
        int sum;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(len));
        sum = len;
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom_range(0, 255));
            frame.push_back(b);
            sum += int'(b);
        end
        frame.push_back(good ? 8'(sum % 256) : 8'((sum % 256) ^ 8'h5A));
    endtask

    // Reference model: what a fully delivered frame must leave behind
    task automatic check_frame(input string tag);
        int len, sum, nw;
        logic [1:0] e;
        logic [31:0] w;
        len = int'(frame[0]);
        if (len == 0 || len > MAXW) begin
            nw = 0;
            e  = 2'b11;
        end else begin
            nw  = len;
            sum = 0;
            for (int i = 0; i <= 4 * len; i++) sum += int'(frame[i]);
            e = (int'(frame[4 * len + 1]) == sum % 256) ? 2'b00 : 2'b01;
        end
        check({tag, ".nwrites"}, 32'(got_addr.size()), 32'(nw));
        for (int i = 0; i < nw && i < got_addr.size(); i++) begin
            w = {frame[4*i+4], frame[4*i+3], frame[4*i+2], frame[4*i+1]};
            check($sformatf("%s.addr[%0d]", tag, i), got_addr[i], 32'(i));
            check($sformatf("%s.data[%0d]", tag, i), got_data[i], w);
        end
        check({tag, ".err"},      32'(err_o),        32'(e));
        check({tag, ".done"},     32'(done_o),       32'(e == 2'b00));
        check({tag, ".core_rst"}, 32'(core_rst_o),   32'(e != 2'b00));
        check({tag, ".words"},    32'(words_o),      32'(nw));
        check({tag, ".ready"},    32'(byte_ready_o), 32'd0);
    endtask

    initial begin
        bit ok;
        int h;
        int len;

        // Reset state
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check_reset_vals("reset");

        // Known-good two-word frame; done appears one cycle after the checksum
        frame = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        for (int i = 0; i < 9; i++) send_byte(frame[i], 1'b0, ok);
        check("fixed.done_before", 32'(done_o), 32'd0);
        send_byte(frame[9], 1'b0, ok);
        check("fixed.done_after", 32'(done_o), 32'd1);
        check_frame("fixed");

        // Same frame with a wrong checksum; later bytes are refused
        do_reset();
        frame[9] = 8'h00;
        send_frame(1'b0);
        check_frame("badcsum");
        send_byte(8'h55, 1'b0, ok);
        check("badcsum.ignored", 32'(ok), 32'd0);
        check("badcsum.nwrites_after", 32'(got_addr.size()), 32'd2);

        // Illegal lengths
        do_reset();
        frame = '{8'h00};
        send_frame(1'b0);
        check_frame("len00");
        do_reset();
        frame = '{8'h41};
        send_frame(1'b0);
        check_frame("len41");

        // Timeout: one word plus one byte, then silence
        do_reset();
        make_frame(2, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(frame[i], 1'b0, ok);
        h = last_hs;
        for (int n = 0; n < 40; n++) begin
            if (err_o != 2'b00) break;
            @(negedge clk);
        end
        check("timeout.latency", 32'(cyc - h), 32'd17);
        check("timeout.err", 32'(err_o), 32'd2);
        repeat (5) @(negedge clk);
        check("timeout.nwrites", 32'(got_addr.size()), 32'd1);
        check("timeout.addr0", got_addr.size() > 0 ? got_addr[0] : 32'hDEAD, 32'd0);
        check("timeout.data0", got_data.size() > 0 ? got_data[0] : 32'hDEAD,
              {frame[4], frame[3], frame[2], frame[1]});
        check("timeout.core_rst", 32'(core_rst_o), 32'd1);

        // Full 64-word image with random valid gaps
        do_reset();
        make_frame(MAXW, 1'b1);
        send_frame(1'b1);
        check_frame("full64");

        // Reset in the middle of a frame, then a clean reload
        do_reset();
        send_byte(8'h02, 1'b0, ok);
        send_byte(8'hAA, 1'b0, ok);
        send_byte(8'hBB, 1'b0, ok);
        rst_i = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst_i = 1'b0;
        check("midrst.nwrites", 32'(got_addr.size()), 32'd0);
        make_frame(int'($urandom_range(1, 8)), 1'b1);
        send_frame(1'b1);
        check_frame("reload");

        // Random frames, good and bad checksums
        for (int k = 0; k < 4; k++) begin
            do_reset();
            len = int'($urandom_range(1, MAXW));
            make_frame(len, k[0]);
            send_frame(1'b1);
            check_frame($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
